ac_op_sequencer: RTL and testbench
==================================

// Module: ac_op_sequencer
// PURPOSE
// Upstream control stage of the accumulator ALU output mux. Accepts an ALU opcode by valid/ready.
// Decodes it to the one-hot mux selects (andbit..shiftbit).
// Holds the selects for a fixed gate-settle window, then pulses ac_load into the accumulator register.
// Shifts repeat the settle/load pair shamt times. A done pulse closes every accepted operation.
// PARAMETERS
// SETTLE_CYC  2  cycles selects are held before each ac_load; covers mux NAND depth; must be >=1 (elab error if 0)
// SHAMT_W     3  width of shift-count input
// PORTS
// clk       in   1        rising-edge clock
// rst_n     in   1        synchronous active-low reset
// op_valid  in   1        opcode/shamt valid
// op_ready  out  1        sequencer idle, can accept
// opcode    in   3        000 AND,001 NOT,010 OR,011 XOR,100 SUM,101 SHIFT,110 NOP,111 illegal
// shamt     in   SHAMT_W  shift passes, used only for SHIFT
// andbit,notbit,orbit,xorbit,sumbit,shiftbit  out 1 each  one-hot mux selects (registered)
// ac_load   out  1        one-cycle accumulator capture strobe
// done      out  1        one-cycle end-of-operation pulse
// illegal   out  1        one-cycle, coincident with done, for opcode 111
// BEHAVIOUR
// - States: IDLE, SETTLE, LOAD, DONE. All outputs registered, except op_ready = (state==IDLE).
// - Reset: state=IDLE, counters 0.
//   - Selects, ac_load, done and illegal are 0.
//   - op_ready=1 from the first cycle after reset. Handshakes while rst_n=0 are ignored.
// - Accept: op_valid&op_ready at edge T0 latches opcode/shamt. Later input changes are ignored.
// - IDLE -> SETTLE for opcodes 000-101, except SHIFT with shamt=0.
//   - One-hot select for the opcode is high from T0+1.
// - IDLE -> DONE for NOP, for illegal, and for SHIFT with shamt=0. No select, no ac_load.
// - SETTLE: lasts exactly SETTLE_CYC cycles (down-counter), then LOAD.
// - LOAD: one cycle, ac_load=1, select still held.
//   - A pass counter starts at shamt for SHIFT and at 1 for all other ops.
//   - If passes remain after this load -> SETTLE, with shiftbit held continuously; else -> DONE.
// - DONE: one cycle. done=1; illegal=1 if opcode was 111. Selects already 0. Next state IDLE.
// - Selects are never two-hot and are 0 in IDLE and DONE.
// - Latency, non-shift op: ac_load at T0+1+SETTLE_CYC, done at T0+2+SETTLE_CYC, op_ready at T0+3+SETTLE_CYC.
// - Latency, SHIFT with k>0: k ac_load pulses spaced SETTLE_CYC+1 apart; done at T0+k*(SETTLE_CYC+1)+1.
// - Latency, NOP/illegal/shift-0: done at T0+1.
// - Max shamt (2^SHAMT_W-1) is legal. No wrap of the pass counter.
// - Reset mid-operation: next edge returns to IDLE.
//   - All strobes and selects drop to 0. No further ac_load. done is not pulsed.
// CONFIGURATION
// AC_SEQ_ABORT_EN defined:
// - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
// - abort=1 in SETTLE or LOAD forces IDLE next cycle.
//   - aborted pulses 1 cycle and selects clear.
//   - In LOAD, the same-cycle ac_load still fires; no later load. done is not pulsed.
// - abort in IDLE/DONE is ignored.
// AC_SEQ_ABORT_EN undefined:
// - Ports abort/aborted are absent. Operations always run to done.
// TESTING
// Reset then SETTLE_CYC=2:
// - XOR (011) accepted at T0 -> xorbit=1 at T0+1..T0+3, ac_load=1 at T0+3 only, done at T0+4, op_ready=1 at T0+5.
// SHIFT shamt=3:
// - shiftbit high continuously, ac_load at T0+3,T0+6,T0+9; done at T0+10.
// - No other select is ever asserted.
// NOP, opcode 111 and SHIFT shamt=0:
// - Each gives done at T0+1, no ac_load, no select; illegal=1 only for 111.
// Back-to-back: op_valid held high with new opcode:
// - Second accept only when op_ready=1. Opcode change during SETTLE does not alter the active select.
// rst_n low at T0+2 of a SUM op:
// - At the next edge all outputs 0 except op_ready=1. No ac_load and no done follow.
// With AC_SEQ_ABORT_EN, abort during 2nd shift SETTLE of shamt=3:
// - Exactly 1 ac_load total, aborted pulse, no done, op_ready next cycle.

Source files
------------

// File: rtl/ac_op_sequencer.sv
// Opcode sequencer for the accumulator ALU mux: decode to one-hot selects, settle, pulse ac_load, close with done.
// Optional abort input/aborted output are built only when AC_SEQ_ABORT_EN is defined.
module ac_op_sequencer #(
   parameter int SETTLE_CYC = 2,
   parameter int SHAMT_W    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         opcode,
   input  logic [SHAMT_W-1:0] shamt,
`ifdef AC_SEQ_ABORT_EN
   input  logic               abort,
   output logic               aborted,
`endif
   output logic               andbit,
   output logic               notbit,
   output logic               orbit,
   output logic               xorbit,
   output logic               sumbit,
   output logic               shiftbit,
   output logic               ac_load,
   output logic               done,
   output logic               illegal
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [2:0] OP_SHIFT = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;
   localparam logic [2:0] OP_ILL   = 3'b111;

   if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("ac_op_sequencer: SETTLE_CYC must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, SETTLE, LOAD, DONE} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      settle_q, settle_d;
   logic [SHAMT_W-1:0] pass_q, pass_d;
   logic [2:0]         op_q, op_d;
   logic [5:0]         sel_q, sel_d;
   logic               load_q, load_d;
   logic               done_q, done_d;
   logic               ill_q, ill_d;
`ifdef AC_SEQ_ABORT_EN
   logic               abort_hit;
   logic               aborted_q, aborted_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         pass_q    <= '0;
         op_q      <= '0;
         sel_q     <= '0;
         load_q    <= 1'b0;
         done_q    <= 1'b0;
         ill_q     <= 1'b0;
`ifdef AC_SEQ_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         pass_q    <= pass_d;
         op_q      <= op_d;
         sel_q     <= sel_d;
         load_q    <= load_d;
         done_q    <= done_d;
         ill_q     <= ill_d;
`ifdef AC_SEQ_ABORT_EN
         aborted_q <= aborted_d;
`endif
      end
   end

   // Pass counter holds the loads still owed, including the one in progress.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      pass_d   = pass_q;
      op_d     = op_q;
`ifdef AC_SEQ_ABORT_EN
      abort_hit = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d     = opcode;
               pass_d   = (opcode == OP_SHIFT) ? shamt : SHAMT_W'(1);
               settle_d = CW'(SETTLE_CYC - 1);
               if (opcode == OP_NOP || opcode == OP_ILL || (opcode == OP_SHIFT && shamt == '0))
                  state_d = DONE;
               else
                  state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == '0)
               state_d = LOAD;
            else
               settle_d = settle_q - 1'b1;
         end
         LOAD: begin
            if (pass_q > SHAMT_W'(1)) begin
               state_d  = SETTLE;
               pass_d   = pass_q - 1'b1;
               settle_d = CW'(SETTLE_CYC - 1);
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef AC_SEQ_ABORT_EN
      if (abort && (state_q == SETTLE || state_q == LOAD)) begin
         state_d   = IDLE;
         abort_hit = 1'b1;
      end
`endif
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      sel_d = '0;
      if (state_d == SETTLE || state_d == LOAD)
         sel_d = 6'b000001 << op_d;
      load_d = (state_d == LOAD);
      done_d = (state_d == DONE);
      ill_d  = (state_d == DONE) && (op_d == OP_ILL);
`ifdef AC_SEQ_ABORT_EN
      aborted_d = abort_hit;
`endif
   end

   assign op_ready = (state_q == IDLE);
   assign {shiftbit, sumbit, xorbit, orbit, notbit, andbit} = sel_q;
   assign ac_load = load_q;
   assign done    = done_q;
   assign illegal = ill_q;
`ifdef AC_SEQ_ABORT_EN
   assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_ac_op_sequencer.sv
// Self-checking bench for ac_op_sequencer: directed cases then random traffic against a timeline model.
// Abort traffic is exercised only when AC_SEQ_ABORT_EN is defined.
module tb_ac_op_sequencer;

   localparam int S  = 2;
   localparam int SW = 3;
`ifdef AC_SEQ_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          op_valid = 1'b0;
   logic [2:0]    opcode = 3'b000;
   logic [SW-1:0] shamt = '0;
   logic          op_ready;
   logic          andbit, notbit, orbit, xorbit, sumbit, shiftbit;
   logic          ac_load, done, illegal;
`ifdef AC_SEQ_ABORT_EN
   logic          abort = 1'b0;
   logic          aborted;
`endif

   int checks = 0;
   int failures = 0;
   int e = 0;

   // Model: the latest accepted op as a timeline (start edge, pass count, cut-off edge).
   bit         haveOp = 1'b0;
   int         t0 = 0;
   int         k = 0;
   int         killE = 32'h7fffffff;
   int         abortE = -10;
   logic [2:0] mOp = 3'b000;

   ac_op_sequencer #(.SETTLE_CYC(S), .SHAMT_W(SW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .op_valid(op_valid),
      .op_ready(op_ready),
      .opcode(opcode),
      .shamt(shamt),
`ifdef AC_SEQ_ABORT_EN
      .abort(abort),
      .aborted(aborted),
`endif
      .andbit(andbit),
      .notbit(notbit),
      .orbit(orbit),
      .xorbit(xorbit),
      .sumbit(sumbit),
      .shiftbit(shiftbit),
      .ac_load(ac_load),
      .done(done),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: got %h, want %h", tag, e, obs, exp);
      end
   endtask

   task automatic computeExpected(output logic [5:0] sel, output bit ld, output bit dn,
                                  output bit il, output bit rdy, output bit ab);
      bit active;
      int len;
      int rel;
      active = haveOp && (e > t0) && (e <= killE);
      len    = k * (S + 1);
      rel    = e - t0;
      sel = '0;
      if (active && k > 0 && rel <= len)
         sel = 6'b000001 << mOp;
      ld  = active && k > 0 && rel <= len && (rel % (S + 1)) == 0;
      dn  = active && (e == t0 + len + 1);
      il  = dn && (mOp == 3'b111);
      rdy = !active || (e > t0 + len + 1);
      ab  = (e == abortE + 1);
   endtask

   // One cycle: check what the previous edge produced, then drive the inputs for the next edge.
   task automatic applyStimulus(input bit rv, input bit v, input logic [2:0] opc,
                                input logic [SW-1:0] sh, input bit ab);
      logic [5:0] xsel;
      bit xld, xdn, xil, xrdy, xab;
      @(negedge clk);
      e++;
      computeExpected(xsel, xld, xdn, xil, xrdy, xab);
      checkOutput("selects", {2'b00, shiftbit, sumbit, xorbit, orbit, notbit, andbit}, {2'b00, xsel});
      checkOutput("ac_load", {7'b0, ac_load}, {7'b0, xld});
      checkOutput("done", {7'b0, done}, {7'b0, xdn});
      checkOutput("illegal", {7'b0, illegal}, {7'b0, xil});
      checkOutput("op_ready", {7'b0, op_ready}, {7'b0, xrdy});
`ifdef AC_SEQ_ABORT_EN
      checkOutput("aborted", {7'b0, aborted}, {7'b0, xab});
      abort = ab;
`endif
      rst_n    = rv;
      op_valid = v;
      opcode   = opc;
      shamt    = sh;
      if (!rv) begin
         killE = e;
      end else if (ABORT_EN && ab && xsel != '0) begin
         killE  = e;
         abortE = e;
      end
      if (rv && v && xrdy) begin
         haveOp = 1'b1;
         t0     = e;
         mOp    = opc;
         k      = (opc == 3'b101) ? int'(sh) : ((opc <= 3'b100) ? 1 : 0);
         killE  = 32'h7fffffff;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b1, 1'b0, 3'($urandom), SW'($urandom), 1'b0);
   endtask

   initial begin
      $display("[TB] start, SETTLE_CYC=%0d", S);
      repeat (3) @(posedge clk);

      applyStimulus(1'b1, 1'b1, 3'b011, '0, 1'b0);
      idleCycles(6);
      applyStimulus(1'b1, 1'b1, 3'b101, SW'(3), 1'b0);
      idleCycles(12);
      applyStimulus(1'b1, 1'b1, 3'b110, SW'(5), 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, 1'b1, 3'b111, SW'(2), 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, 1'b1, 3'b101, '0, 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, 1'b1, 3'b101, '1, 1'b0);
      idleCycles(25);

      for (int i = 0; i < 24; i++)
         applyStimulus(1'b1, 1'b1, 3'($urandom_range(0, 5)), SW'($urandom_range(1, 2)), 1'b0);
      idleCycles(4);

      applyStimulus(1'b1, 1'b1, 3'b100, '0, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, 3'b000, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'b010, '0, 1'b0);
      idleCycles(6);

      if (ABORT_EN) begin
         applyStimulus(1'b1, 1'b1, 3'b101, SW'(3), 1'b0);
         idleCycles(3);
         applyStimulus(1'b1, 1'b0, 3'b000, '0, 1'b1);
         idleCycles(12);
      end

      for (int i = 0; i < 3000; i++)
         applyStimulus(($urandom % 40) != 0, ($urandom % 2) == 0, 3'($urandom), SW'($urandom),
                       ($urandom % 12) == 0);
      idleCycles(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
